// File: rtl/cpu_dd.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dd
// Description : CPU-side endpoint of the 64DD interface. Captures command and
//               buffer-manager requests from the N64 side. Exposes them to the
//               soft CPU as a 4-word register window. Returns CPU-written
//               status/data and the cmd_ack handshake. Raises a level
//               interrupt on pending events.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   i_dd_hard_reset       : N64 hard-reset level
//   i_dd_cmd_request      : 1-cycle pulse, i_dd_command/i_dd_data_input valid
//   o_dd_cmd_ack          : 1-cycle pulse, command completed
//   i_dd_command          : ASIC command byte
//   o_dd_status           : ASIC status returned to N64
//   i_dd_data_input       : command argument
//   o_dd_data_output      : command result
//   i_dd_bm_request       : 1-cycle pulse, i_dd_bm_control valid
//   i_dd_bm_control       : buffer-manager control word
//   o_dd_bm_status        : buffer-manager status
//   i_request/i_write     : CPU bus strobe and direction
//   i_address/i_wdata     : CPU byte address and write data
//   o_rdata/o_ack         : CPU read data (valid with ack), access acknowledge
//   o_irq                 : level interrupt to the CPU
// Register map (index = address[3:2])
//   0 SCR  : [0] cmd_pend [1] bm_pend [2] hr_pend [3] hard_reset
//            [4] cmd_ovr [5] bm_ovr [10:8] irq_en {hr,bm,cmd}
//   1 CMD  : [23:16] command, [15:0] data_input (read only)
//   2 STAT : [31:16] status, [15:0] data_output
//   3 BM   : [31:16] bm_control (read only), [15:0] bm_status
// ============================================================================
module cpu_dd #(
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_dd_hard_reset,
  input  logic                     i_dd_cmd_request,
  output logic                     o_dd_cmd_ack,
  input  logic [7:0]               i_dd_command,
  output logic [15:0]              o_dd_status,
  input  logic [15:0]              i_dd_data_input,
  output logic [15:0]              o_dd_data_output,
  input  logic                     i_dd_bm_request,
  input  logic [15:0]              i_dd_bm_control,
  output logic [15:0]              o_dd_bm_status,
  input  logic                     i_request,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic                     o_ack,
  output logic                     o_irq
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] c_IDX_SCR  = 2'd0;
  localparam logic [1:0] c_IDX_STAT = 2'd2;
  localparam logic [1:0] c_IDX_BM   = 2'd3;

  logic [0:0]  r_state;
  logic        r_ack;
  logic        r_write;
  logic [1:0]  r_idx;
  logic [31:0] r_wdata;

  logic [7:0]  r_cmd;
  logic [15:0] r_din;
  logic [15:0] r_bm_ctrl;
  logic [15:0] r_status;
  logic [15:0] r_dout;
  logic [15:0] r_bm_status;
  logic        r_cmd_pend;
  logic        r_bm_pend;
  logic        r_hr_pend;
  logic        r_cmd_ovr;
  logic        r_bm_ovr;
  logic [2:0]  r_irq_en;
  logic        r_hr_d;
  logic        r_cmd_ack;
  logic        r_irq;

  logic        w_wr_scr;
  logic        w_wr_stat;
  logic        w_wr_bm;
  logic        w_hr_rise;
  logic        w_cmd_req;
  logic        w_cmd_clr;
  logic        w_cmd_base;
  logic        w_bm_req;
  logic        w_bm_clr;
  logic        w_bm_base;
  logic [31:0] w_rd;
  logic        w_unused;

  // Only address[3:2] select a register; the remaining bits are don't-care.
  assign w_unused = ^i_address;

  // Write side effects land on the edge that closes the ack cycle.
  assign w_wr_scr  = r_ack & r_write & (r_idx == c_IDX_SCR);
  assign w_wr_stat = r_ack & r_write & (r_idx == c_IDX_STAT);
  assign w_wr_bm   = r_ack & r_write & (r_idx == c_IDX_BM);

  assign w_hr_rise = i_dd_hard_reset & ~r_hr_d;

  // Clearing writes are applied before a same-cycle capture, so a request
  // arriving with the clear sees an empty slot and does not overrun.
  assign w_cmd_req  = i_dd_cmd_request & ~i_dd_hard_reset;
  assign w_cmd_clr  = w_wr_scr & r_wdata[0];
  assign w_cmd_base = r_cmd_pend & ~w_cmd_clr;
  assign w_bm_req   = i_dd_bm_request & ~i_dd_hard_reset;
  assign w_bm_clr   = w_wr_scr & r_wdata[1];
  assign w_bm_base  = r_bm_pend & ~w_bm_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_write     <= 1'b0;
      r_idx       <= 2'd0;
      r_wdata     <= 32'd0;
      r_cmd       <= 8'd0;
      r_din       <= 16'd0;
      r_bm_ctrl   <= 16'd0;
      r_status    <= 16'd0;
      r_dout      <= 16'd0;
      r_bm_status <= 16'd0;
      r_cmd_pend  <= 1'b0;
      r_bm_pend   <= 1'b0;
      r_hr_pend   <= 1'b0;
      r_cmd_ovr   <= 1'b0;
      r_bm_ovr    <= 1'b0;
      r_irq_en    <= 3'd0;
      r_hr_d      <= 1'b0;
      r_cmd_ack   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_hr_d    <= i_dd_hard_reset;
      r_cmd_ack <= w_cmd_clr & r_cmd_pend;
      r_irq     <= (r_cmd_pend & r_irq_en[0]) | (r_bm_pend & r_irq_en[1]) |
                   (r_hr_pend & r_irq_en[2]);

      case (r_state)
        S_IDLE: begin
          if (i_request) begin
            r_state <= S_WAIT;
            r_ack   <= 1'b1;
            r_write <= i_write;
            r_idx   <= i_address[3:2];
            r_wdata <= i_wdata;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase

      if (w_wr_scr)  r_irq_en <= r_wdata[10:8];
      if (w_wr_stat) begin
        r_status <= r_wdata[31:16];
        r_dout   <= r_wdata[15:0];
      end
      if (w_wr_bm)   r_bm_status <= r_wdata[15:0];

      if (w_cmd_req && !w_cmd_base) begin
        r_cmd <= i_dd_command;
        r_din <= i_dd_data_input;
      end
      if (w_bm_req && !w_bm_base) r_bm_ctrl <= i_dd_bm_control;

      // A hard-reset edge discards all outstanding request state.
      r_cmd_pend <= (w_cmd_base | w_cmd_req) & ~w_hr_rise;
      r_bm_pend  <= (w_bm_base | w_bm_req) & ~w_hr_rise;
      r_cmd_ovr  <= ((r_cmd_ovr & ~(w_wr_scr & r_wdata[4])) |
                     (w_cmd_req & w_cmd_base)) & ~w_hr_rise;
      r_bm_ovr   <= ((r_bm_ovr & ~(w_wr_scr & r_wdata[5])) |
                     (w_bm_req & w_bm_base)) & ~w_hr_rise;
      r_hr_pend  <= (r_hr_pend & ~(w_wr_scr & r_wdata[2])) | w_hr_rise;
    end
  end

  always_comb begin
    w_rd = 32'd0;
    case (r_idx)
      2'd0:    w_rd = {21'd0, r_irq_en, 2'b00, r_bm_ovr, r_cmd_ovr,
                       i_dd_hard_reset, r_hr_pend, r_bm_pend, r_cmd_pend};
      2'd1:    w_rd = {8'd0, r_cmd, r_din};
      2'd2:    w_rd = {r_status, r_dout};
      default: w_rd = {r_bm_ctrl, r_bm_status};
    endcase
  end

  assign o_rdata          = r_ack ? w_rd : 32'd0;
  assign o_ack            = r_ack;
  assign o_irq            = r_irq;
  assign o_dd_cmd_ack     = r_cmd_ack;
  assign o_dd_status      = r_status;
  assign o_dd_data_output = r_dout;
  assign o_dd_bm_status   = r_bm_status;

endmodule
`default_nettype wire
